delay_timer_ms: RTL and testbench
=================================

DELAY_TIMER_MS -- requirements
Module: delay_timer_ms

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the millisecond count.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on clk_1ms, legal values 2 to 4.
REQ-003 SHALL have port clk, input, 1: system clock, 50 MHz.
REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port clk_1ms, input, 1: toggling level from the 1 ms divider; each transition, rising or falling, is one tick.
REQ-006 SHALL have port start, input, 1: load load_ms and begin the countdown.
REQ-007 SHALL have port load_ms, input, CNT_W: countdown length in ticks, sampled only when start=1.
REQ-008 SHALL have port pause, input, 1: level signal; while it is 1, ticks do not decrement the count.
REQ-009 SHALL have port tick, output, 1: one-cycle pulse for each detected clk_1ms transition.
REQ-010 SHALL have port busy, output, 1: high while in RUN.
REQ-011 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port remaining_ms, output, CNT_W: registered count of ticks still to go.

Function
REQ-013 SHALL pass clk_1ms through SYNC_STAGES flops, then one history flop; tick = last sync stage XOR history.
REQ-014 SHALL assert tick exactly one clk cycle per clk_1ms transition, SYNC_STAGES+1 clk edges after the transition is first sampled.
REQ-015 SHALL NOT emit a tick for the first synchronized sample after reset, regardless of the clk_1ms level; a primed flag gates tick until the history flop holds a valid sample.
REQ-016 SHALL implement FSM states IDLE, RUN, FIN.
REQ-017 IDLE: on start=1 with load_ms!=0, SHALL load remaining_ms=load_ms and go to RUN; with load_ms=0, SHALL go to FIN and leave remaining_ms at 0.
REQ-018 RUN: on tick=1 and pause=0 and start=0, SHALL decrement remaining_ms by 1; if the value before the decrement is 1, it SHALL go to FIN.
REQ-019 RUN: start=1 SHALL reload from load_ms, following the same rules as REQ-017; start SHALL take priority over a tick in the same cycle.
REQ-020 FIN: SHALL assert done for exactly this one cycle, then go to IDLE; start=1 in FIN SHALL be honoured as in IDLE, with done still asserted.
REQ-021 remaining_ms SHALL never wrap below 0; a tick in IDLE or FIN SHALL have no effect on it.
REQ-022 busy SHALL equal (state==RUN); done SHALL equal (state==FIN). Both SHALL be registered-state decodes with no combinational path from the inputs.
REQ-023 pause SHALL have no effect outside RUN; ticks while paused SHALL be discarded and not accumulated.

Reset
REQ-024 While rst=1, all flops SHALL clear asynchronously: state=IDLE, remaining_ms=0, busy=0, done=0, tick=0, sync/history/primed=0.
REQ-025 Reset asserted mid-countdown SHALL abort the count with no done pulse; after release the block SHALL sit in IDLE.

Structure
REQ-026 Package pong_timer_pkg SHALL hold the FSM state enum (IDLE, RUN, FIN) and the CNT_W default constant.
REQ-027 Synchronizer, history flop, primed flag and edge XOR SHALL form sub-module tick_sync (ports clk, rst, level_in, tick_out; parameter SYNC_STAGES).
REQ-028 The whole block SHALL use the single clock clk, with no derived clocks; clk_1ms SHALL be treated only as data.

Verification
REQ-029 Reset release with clk_1ms=1 held -> no tick pulse within 10 clk cycles.
REQ-030 start with load_ms=3, clk_1ms toggled every 20 clk cycles -> remaining_ms steps 3,2,1,0, with done high for one cycle in the cycle after the third tick, and busy low after that.
REQ-031 start with load_ms=0 -> busy never high, done pulses exactly one cycle, 1 clk cycle after start.
REQ-032 load_ms=5, pause=1 across 2 ticks after the first tick -> remaining_ms holds at 4 during pause, and done arrives after 7 total ticks.
REQ-033 start with load_ms=9 asserted in the same cycle as a tick while RUN with remaining_ms=2 -> remaining_ms=9 next cycle, no decrement, no done.
REQ-034 rst pulse while RUN with remaining_ms=4 -> outputs cleared immediately, no done pulse, state IDLE after release.

Source files
------------

// File: rtl/pong_timer_pkg.sv
// Shared types and defaults for the millisecond delay timer.
package pong_timer_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/tick_sync.sv
// Synchronizes the 1 ms toggle level and emits one pulse per transition.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic tick_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   hist_q;
    logic                   primed_q;

    // vld_q tracks which sync stages hold a real sample, so the first
    // compare against the reset value of hist_q is never reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            vld_q    <= '0;
            hist_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], level_in};
            vld_q    <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            hist_q   <= sync_q[SYNC_STAGES-1];
            primed_q <= vld_q[SYNC_STAGES-1];
        end
    end

    assign tick_out = primed_q & (sync_q[SYNC_STAGES-1] ^ hist_q);

endmodule

// File: rtl/delay_timer_ms.sv
// Millisecond countdown timer driven by a toggling 1 ms level, with pause.
module delay_timer_ms
    import pong_timer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_1ms,
    input  logic             start,
    input  logic [CNT_W-1:0] load_ms,
    input  logic             pause,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining_ms
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    tick_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_tick_sync (
        .clk     (clk),
        .rst     (rst),
        .level_in(clk_1ms),
        .tick_out(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // start wins over a coincident tick in every state
        if (start) begin
            if (load_ms != '0) begin
                cnt_d   = load_ms;
                state_d = RUN;
            end else begin
                cnt_d   = '0;
                state_d = FIN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (tick && !pause) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            cnt_d   = '0;
                            state_d = FIN;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == FIN);
    assign remaining_ms = cnt_q;

endmodule

// File: tb/tb_delay_timer_ms.sv
// Directed bench for delay_timer_ms using the default parameters.
module tb_delay_timer_ms;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_1ms;
    logic        start;
    logic [15:0] load_ms;
    logic        pause;
    logic        tick;
    logic        busy;
    logic        done;
    logic [15:0] remaining_ms;

    int checks   = 0;
    int failures = 0;
    int tick_cnt = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int t0, d0, b0;

    delay_timer_ms dut (
        .clk         (clk),
        .rst         (rst),
        .clk_1ms     (clk_1ms),
        .start       (start),
        .load_ms     (load_ms),
        .pause       (pause),
        .tick        (tick),
        .busy        (busy),
        .done        (done),
        .remaining_ms(remaining_ms)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt++;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clk_1ms transition, then wait long enough for the tick to land
    task automatic step();
        clk_1ms = ~clk_1ms;
        cyc(20);
    endtask

    task automatic pulse_start(input logic [15:0] v);
        start   = 1'b1;
        load_ms = v;
        cyc(1);
        start   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_1ms = 1'b1; start = 1'b0; load_ms = '0; pause = 1'b0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rem", remaining_ms, 0);
        chk("rst_tick", tick, 0);

        // release with clk_1ms high: no spurious tick
        t0 = tick_cnt;
        rst = 1'b0;
        cyc(10);
        chk("no_tick_after_rst", tick_cnt - t0, 0);
        chk("idle_busy", busy, 0);

        // load 3, plain countdown
        t0 = tick_cnt; d0 = done_cnt;
        pulse_start(16'd3);
        chk("l3_busy", busy, 1);
        chk("l3_rem3", remaining_ms, 3);
        step();
        chk("l3_rem2", remaining_ms, 2);
        step();
        chk("l3_rem1", remaining_ms, 1);
        clk_1ms = ~clk_1ms;
        cyc(2);
        chk("l3_tick", tick, 1);
        chk("l3_done_early", done, 0);
        cyc(1);
        chk("l3_done", done, 1);
        chk("l3_rem0", remaining_ms, 0);
        chk("l3_busy_fin", busy, 0);
        cyc(1);
        chk("l3_done_off", done, 0);
        chk("l3_busy_off", busy, 0);
        cyc(17);
        chk("l3_ticks", tick_cnt - t0, 3);
        chk("l3_done_cnt", done_cnt - d0, 1);

        // load 0: straight to FIN
        d0 = done_cnt; b0 = busy_cnt;
        pulse_start(16'd0);
        chk("l0_done", done, 1);
        chk("l0_busy", busy, 0);
        cyc(1);
        chk("l0_done_off", done, 0);
        cyc(5);
        chk("l0_done_cnt", done_cnt - d0, 1);
        chk("l0_busy_cnt", busy_cnt - b0, 0);
        chk("l0_rem", remaining_ms, 0);

        // load 5 with two ticks discarded while paused
        d0 = done_cnt;
        pulse_start(16'd5);
        step();
        chk("p_rem4", remaining_ms, 4);
        pause = 1'b1;
        step();
        chk("p_hold1", remaining_ms, 4);
        step();
        chk("p_hold2", remaining_ms, 4);
        chk("p_busy", busy, 1);
        pause = 1'b0;
        step();
        chk("p_rem3", remaining_ms, 3);
        step();
        step();
        chk("p_rem1", remaining_ms, 1);
        chk("p_no_done", done_cnt - d0, 0);
        clk_1ms = ~clk_1ms;
        cyc(3);
        chk("p_done7", done, 1);
        cyc(1);
        chk("p_done_off", done, 0);
        cyc(16);

        // restart coinciding with a tick at remaining 2
        d0 = done_cnt;
        pulse_start(16'd5);
        step(); step(); step();
        chk("r_rem2", remaining_ms, 2);
        clk_1ms = ~clk_1ms;
        cyc(2);
        chk("r_tick", tick, 1);
        pulse_start(16'd9);
        chk("r_rem9", remaining_ms, 9);
        chk("r_busy", busy, 1);
        chk("r_done", done, 0);
        cyc(17);
        chk("r_rem9_hold", remaining_ms, 9);
        chk("r_no_done", done_cnt - d0, 0);

        // async reset mid-countdown
        step(); step(); step(); step(); step();
        chk("a_rem4", remaining_ms, 4);
        d0 = done_cnt;
        #5 rst = 1'b1;
        #1;
        chk("a_rem_clr", remaining_ms, 0);
        chk("a_busy_clr", busy, 0);
        chk("a_done_clr", done, 0);
        chk("a_tick_clr", tick, 0);
        cyc(2);
        rst = 1'b0;
        cyc(10);
        chk("a_idle_busy", busy, 0);
        chk("a_idle_rem", remaining_ms, 0);
        chk("a_no_done", done_cnt - d0, 0);

        // ticks in IDLE do nothing
        step();
        chk("i_rem", remaining_ms, 0);
        chk("i_busy", busy, 0);
        chk("i_no_done", done_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
